// File: rtl/car_sensor_driver_if.sv
// Request handshake and sensor-waveform bundle of the parking-gate car driver.
// The driver side uses the slave modport; the requester/observer uses master.
interface car_sensor_driver_if;
  logic req_valid;
  logic req_dir;
  logic req_ready;
  logic outer;
  logic inner;
  logic busy;
  logic done;
  logic done_dir;

  modport master (
    output req_valid,
    output req_dir,
    input  req_ready,
    input  outer,
    input  inner,
    input  busy,
    input  done,
    input  done_dir
  );

  modport slave (
    input  req_valid,
    input  req_dir,
    output req_ready,
    output outer,
    output inner,
    output busy,
    output done,
    output done_dir
  );
endinterface

// File: rtl/car_sensor_driver.sv
// Replays the outer/inner photo-sensor waveform of one car crossing the gate.
// Define CAR_DRV_GAP_EN to force GAP_CYCLES all-clear cycles between cars.
module car_sensor_driver #(
  parameter int PHASE_CYCLES = 4,
  parameter int GAP_CYCLES   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  car_sensor_driver_if.slave   bus
);

`ifdef CAR_DRV_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  localparam int MAX_LOAD = (GAP_EN && (GAP_CYCLES > PHASE_CYCLES)) ? GAP_CYCLES : PHASE_CYCLES;
  localparam int CW       = $clog2(MAX_LOAD + 1);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] PH_LOAD  = CW'(PHASE_CYCLES - 32'sd1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 32'sd1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PH1  = 3'd1;
  localparam logic [2:0] ST_PH2  = 3'd2;
  localparam logic [2:0] ST_PH3  = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  logic [2:0]    state_r, state_nx_s;
  logic [CW-1:0] cnt_r, cnt_nx_s;
  logic          dir_r, dir_nx_s;
  logic          accept_s;

  logic ready_r, outer_r, inner_r, busy_r, done_r, done_dir_r;
  logic ready_nx_s, outer_nx_s, inner_nx_s, busy_nx_s, done_nx_s, done_dir_nx_s;

  assign accept_s = bus.req_valid & ready_r & (state_r == ST_IDLE);

  // State, phase counter and latched direction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      dir_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      dir_r   <= dir_nx_s;
    end
  end

  // Next-state logic: each phase holds for PHASE_CYCLES, then advances.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    dir_nx_s   = dir_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nx_s = ST_PH1;
          cnt_nx_s   = PH_LOAD;
          dir_nx_s   = bus.req_dir;
        end else begin
          cnt_nx_s   = CNT_ZERO;
        end
      end
      ST_PH1, ST_PH2: begin
        if (cnt_r == CNT_ZERO) begin
          state_nx_s = (state_r == ST_PH1) ? ST_PH2 : ST_PH3;
          cnt_nx_s   = PH_LOAD;
        end else begin
          cnt_nx_s   = cnt_r - CNT_ONE;
        end
      end
      ST_PH3: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_nx_s   = cnt_r - CNT_ONE;
        end else if (GAP_EN) begin
          state_nx_s = ST_GAP;
          cnt_nx_s   = GAP_LOAD;
        end else begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = CNT_ZERO;
        end
      end
      ST_GAP: begin
        if (GAP_EN && (cnt_r != CNT_ZERO)) begin
          cnt_nx_s   = cnt_r - CNT_ONE;
        end else begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = CNT_ZERO;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = CNT_ZERO;
        dir_nx_s   = 1'b0;
      end
    endcase
  end

  // Output decode; registered below so waveforms trail the state by one cycle.
  always_comb begin
    outer_nx_s    = 1'b0;
    inner_nx_s    = 1'b0;
    busy_nx_s     = 1'b0;
    case (state_r)
      ST_PH1: begin
        outer_nx_s = ~dir_r;
        inner_nx_s = dir_r;
        busy_nx_s  = 1'b1;
      end
      ST_PH2: begin
        outer_nx_s = 1'b1;
        inner_nx_s = 1'b1;
        busy_nx_s  = 1'b1;
      end
      ST_PH3: begin
        outer_nx_s = dir_r;
        inner_nx_s = ~dir_r;
        busy_nx_s  = 1'b1;
      end
      default: begin
        outer_nx_s = 1'b0;
        inner_nx_s = 1'b0;
        busy_nx_s  = 1'b0;
      end
    endcase
    // busy_r still high here means the last phase just ended.
    done_nx_s     = busy_r & ((state_r == ST_IDLE) | (state_r == ST_GAP));
    done_dir_nx_s = done_nx_s & dir_r;
    ready_nx_s    = (state_r == ST_IDLE) & ~accept_s;
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_r    <= 1'b0;
      outer_r    <= 1'b0;
      inner_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      done_dir_r <= 1'b0;
    end else begin
      ready_r    <= ready_nx_s;
      outer_r    <= outer_nx_s;
      inner_r    <= inner_nx_s;
      busy_r     <= busy_nx_s;
      done_r     <= done_nx_s;
      done_dir_r <= done_dir_nx_s;
    end
  end

  assign bus.req_ready = ready_r;
  assign bus.outer     = outer_r;
  assign bus.inner     = inner_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.done_dir  = done_dir_r;

endmodule
